// File: rtl/axi4_lite_arbiter_2to1_pkg.sv
// rtl/axi4_lite_arbiter_2to1_pkg.sv - shared config struct, engine state enums and round-robin pick helper
package axi4_lite_arbiter_2to1_pkg;

    typedef struct packed {
        int A;
        int N;
        int I;
    } axi4_lite_cfg_t;

    localparam axi4_lite_cfg_t AXI4_LITE_CFG_DEFAULT = '{A: 32, N: 4, I: 4};

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } arb_wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RESP = 2'd2
    } arb_rd_state_t;

    // On a tie the master that did not finish last wins; otherwise the lone requester.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/axi4_lite_arbiter_2to1_if.sv
// rtl/axi4_lite_arbiter_2to1_if.sv - AXI4-Lite bundle with master/slave modports
interface axi4_lite_arbiter_2to1_if
    import axi4_lite_arbiter_2to1_pkg::*;
#(
    parameter axi4_lite_cfg_t CFG = AXI4_LITE_CFG_DEFAULT
);

    logic [CFG.I-1:0]   awid;
    logic [CFG.A-1:0]   awaddr;
    logic [2:0]         awprot;
    logic               awvalid;
    logic               awready;

    logic [8*CFG.N-1:0] wdata;
    logic [CFG.N-1:0]   wstrb;
    logic               wvalid;
    logic               wready;

    logic [CFG.I-1:0]   bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;

    logic [CFG.I-1:0]   arid;
    logic [CFG.A-1:0]   araddr;
    logic [2:0]         arprot;
    logic               arvalid;
    logic               arready;

    logic [CFG.I-1:0]   rid;
    logic [8*CFG.N-1:0] rdata;
    logic [1:0]         rresp;
    logic               rvalid;
    logic               rready;

    modport master (
        output awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output arid, araddr, arprot, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );

    modport slave (
        input  awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  arid, araddr, arprot, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_arbiter_2to1_rr_arb2.sv
// rtl/axi4_lite_arbiter_2to1_rr_arb2.sv - 2-way round-robin grant register, one per channel engine
module axi4_lite_arbiter_2to1_rr_arb2
    import axi4_lite_arbiter_2to1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    input  logic       done,
    output logic       grant
);

    logic grant_q, grant_d;
    logic last_q, last_d;

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        if (take && (req != 2'b00)) begin
            grant_d = rr_pick(req, last_q);
        end
        if (done) begin
            last_d = grant_q;
        end
    end

    // last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// rtl/axi4_lite_arbiter_2to1.sv - two-master to one-slave AXI4-Lite arbiter
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding transaction each.
module axi4_lite_arbiter_2to1
    import axi4_lite_arbiter_2to1_pkg::*;
#(
    parameter axi4_lite_cfg_t CFG = AXI4_LITE_CFG_DEFAULT
) (
    input  logic                     aclk,
    input  logic                     areset,
    axi4_lite_arbiter_2to1_if.slave  axi4_s [2],
    axi4_lite_arbiter_2to1_if.master axi4_m
);

    // ---------------- write engine ----------------
    arb_wr_state_t wr_state_q, wr_state_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          wr_g, wr_done;
    logic [1:0]    wr_req;
    logic          sel_awvalid, sel_wvalid, sel_bready;
    logic          m_awvalid, m_wvalid, m_bready;
    logic [1:0]    s_awready, s_wready, s_bvalid;

    logic [CFG.I-1:0]   sel_awid;
    logic [CFG.A-1:0]   sel_awaddr;
    logic [8*CFG.N-1:0] sel_wdata;
    logic [CFG.N-1:0]   sel_wstrb;

    assign wr_req      = {axi4_s[1].awvalid, axi4_s[0].awvalid};
    assign sel_awvalid = wr_g ? axi4_s[1].awvalid : axi4_s[0].awvalid;
    assign sel_wvalid  = wr_g ? axi4_s[1].wvalid  : axi4_s[0].wvalid;
    assign sel_bready  = wr_g ? axi4_s[1].bready  : axi4_s[0].bready;

    axi4_lite_arbiter_2to1_rr_arb2 u_wr_arb (
        .clk   (aclk),
        .rst   (areset),
        .req   (wr_req),
        .take  (wr_state_q == W_IDLE),
        .done  (wr_done),
        .grant (wr_g)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wr_done    = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        s_awready  = 2'b00;
        s_wready   = 2'b00;
        s_bvalid   = 2'b00;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_req != 2'b00) begin
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                // The done flags mask a channel once its beat is accepted, so a
                // master already presenting its next AW or W cannot slip a second beat in.
                m_awvalid       = sel_awvalid & ~aw_done_q;
                m_wvalid        = sel_wvalid & ~w_done_q;
                s_awready[wr_g] = axi4_m.awready & ~aw_done_q;
                s_wready[wr_g]  = axi4_m.wready & ~w_done_q;
                aw_done_d       = aw_done_q | (m_awvalid & axi4_m.awready);
                w_done_d        = w_done_q | (m_wvalid & axi4_m.wready);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            W_RESP: begin
                m_bready       = sel_bready;
                s_bvalid[wr_g] = axi4_m.bvalid;
                if (axi4_m.bvalid && sel_bready) begin
                    wr_state_d = W_IDLE;
                    wr_done    = 1'b1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    assign sel_awid   = wr_g ? axi4_s[1].awid   : axi4_s[0].awid;
    assign sel_awaddr = wr_g ? axi4_s[1].awaddr : axi4_s[0].awaddr;
    assign sel_wdata  = wr_g ? axi4_s[1].wdata  : axi4_s[0].wdata;
    assign sel_wstrb  = wr_g ? axi4_s[1].wstrb  : axi4_s[0].wstrb;

    assign axi4_m.awid    = sel_awid;
    assign axi4_m.awaddr  = sel_awaddr;
    assign axi4_m.awprot  = wr_g ? axi4_s[1].awprot : axi4_s[0].awprot;
    assign axi4_m.awvalid = m_awvalid;
    assign axi4_m.wdata   = sel_wdata;
    assign axi4_m.wstrb   = sel_wstrb;
    assign axi4_m.wvalid  = m_wvalid;
    assign axi4_m.bready  = m_bready;

    assign axi4_s[0].awready = s_awready[0];
    assign axi4_s[1].awready = s_awready[1];
    assign axi4_s[0].wready  = s_wready[0];
    assign axi4_s[1].wready  = s_wready[1];
    assign axi4_s[0].bvalid  = s_bvalid[0];
    assign axi4_s[1].bvalid  = s_bvalid[1];
    assign axi4_s[0].bid     = axi4_m.bid;
    assign axi4_s[1].bid     = axi4_m.bid;
    assign axi4_s[0].bresp   = axi4_m.bresp;
    assign axi4_s[1].bresp   = axi4_m.bresp;

    // ---------------- read engine ----------------
    arb_rd_state_t rd_state_q, rd_state_d;
    logic          rd_g, rd_done;
    logic [1:0]    rd_req;
    logic          sel_arvalid, sel_rready;
    logic          m_arvalid, m_rready;
    logic [1:0]    s_arready, s_rvalid;

    logic [CFG.I-1:0] sel_arid;
    logic [CFG.A-1:0] sel_araddr;

    assign rd_req      = {axi4_s[1].arvalid, axi4_s[0].arvalid};
    assign sel_arvalid = rd_g ? axi4_s[1].arvalid : axi4_s[0].arvalid;
    assign sel_rready  = rd_g ? axi4_s[1].rready  : axi4_s[0].rready;

    axi4_lite_arbiter_2to1_rr_arb2 u_rd_arb (
        .clk   (aclk),
        .rst   (areset),
        .req   (rd_req),
        .take  (rd_state_q == R_IDLE),
        .done  (rd_done),
        .grant (rd_g)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        rd_done    = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s_arready  = 2'b00;
        s_rvalid   = 2'b00;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_req != 2'b00) begin
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                m_arvalid       = sel_arvalid;
                s_arready[rd_g] = axi4_m.arready;
                if (sel_arvalid && axi4_m.arready) begin
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                m_rready       = sel_rready;
                s_rvalid[rd_g] = axi4_m.rvalid;
                if (axi4_m.rvalid && sel_rready) begin
                    rd_state_d = R_IDLE;
                    rd_done    = 1'b1;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    assign sel_arid   = rd_g ? axi4_s[1].arid   : axi4_s[0].arid;
    assign sel_araddr = rd_g ? axi4_s[1].araddr : axi4_s[0].araddr;

    assign axi4_m.arid    = sel_arid;
    assign axi4_m.araddr  = sel_araddr;
    assign axi4_m.arprot  = rd_g ? axi4_s[1].arprot : axi4_s[0].arprot;
    assign axi4_m.arvalid = m_arvalid;
    assign axi4_m.rready  = m_rready;

    assign axi4_s[0].arready = s_arready[0];
    assign axi4_s[1].arready = s_arready[1];
    assign axi4_s[0].rvalid  = s_rvalid[0];
    assign axi4_s[1].rvalid  = s_rvalid[1];
    assign axi4_s[0].rid     = axi4_m.rid;
    assign axi4_s[1].rid     = axi4_m.rid;
    assign axi4_s[0].rdata   = axi4_m.rdata;
    assign axi4_s[1].rdata   = axi4_m.rdata;
    assign axi4_s[0].rresp   = axi4_m.rresp;
    assign axi4_s[1].rresp   = axi4_m.rresp;

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// tb/tb_axi4_lite_arbiter_2to1.sv - directed self-checking bench for the 2:1 AXI4-Lite arbiter
module tb_axi4_lite_arbiter_2to1;
    import axi4_lite_arbiter_2to1_pkg::*;

    localparam axi4_lite_cfg_t CFG = AXI4_LITE_CFG_DEFAULT;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   aw_beats = 0, w_beats = 0, b_beats = 0;
    int   aw0, w0, b0;

    axi4_lite_arbiter_2to1_if #(.CFG(CFG)) s_if [2] ();
    axi4_lite_arbiter_2to1_if #(.CFG(CFG)) m_if ();

    axi4_lite_arbiter_2to1 #(.CFG(CFG)) dut (
        .aclk   (aclk),
        .areset (areset),
        .axi4_s (s_if),
        .axi4_m (m_if)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (m_if.awvalid && m_if.awready) aw_beats <= aw_beats + 1;
        if (m_if.wvalid && m_if.wready)   w_beats  <= w_beats + 1;
        if (m_if.bvalid && m_if.bready)   b_beats  <= b_beats + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [14:0] hs_outs();
        return {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
                s_if[0].awready, s_if[0].wready, s_if[0].bvalid, s_if[0].arready, s_if[0].rvalid,
                s_if[1].awready, s_if[1].wready, s_if[1].bvalid, s_if[1].arready, s_if[1].rvalid};
    endfunction

    task automatic init_inputs();
        s_if[0].awid = 4'd1; s_if[0].awaddr = '0; s_if[0].awprot = '0; s_if[0].awvalid = 1'b0;
        s_if[0].wdata = '0; s_if[0].wstrb = '0; s_if[0].wvalid = 1'b0; s_if[0].bready = 1'b0;
        s_if[0].arid = 4'd1; s_if[0].araddr = '0; s_if[0].arprot = '0; s_if[0].arvalid = 1'b0;
        s_if[0].rready = 1'b0;
        s_if[1].awid = 4'd3; s_if[1].awaddr = '0; s_if[1].awprot = '0; s_if[1].awvalid = 1'b0;
        s_if[1].wdata = '0; s_if[1].wstrb = '0; s_if[1].wvalid = 1'b0; s_if[1].bready = 1'b0;
        s_if[1].arid = 4'd2; s_if[1].araddr = '0; s_if[1].arprot = '0; s_if[1].arvalid = 1'b0;
        s_if[1].rready = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;
        m_if.arready = 1'b0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 1'b0;
    endtask

    initial begin
        logic g;
        init_inputs();

        // reset state
        #12;
        chk("reset_outs", 64'(hs_outs()), 64'h0);
        @(posedge aclk);
        #1 areset = 1'b0;

        // single write from master 1, zero-wait slave
        s_if[1].awaddr = 32'h10; s_if[1].awvalid = 1'b1;
        s_if[1].wdata = 32'hA5A5_A5A5; s_if[1].wstrb = 4'hF; s_if[1].wvalid = 1'b1;
        s_if[1].bready = 1'b1;
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        chk("w1_idle_no_fwd", 64'({m_if.awvalid, m_if.wvalid}), 64'h0);
        tick();
        chk("w1_addr_valids", 64'({m_if.awvalid, m_if.wvalid}), 64'h3);
        chk("w1_awaddr", 64'(m_if.awaddr), 64'h10);
        chk("w1_wdata", 64'(m_if.wdata), 64'hA5A5_A5A5);
        chk("w1_awready", 64'({s_if[1].awready, s_if[0].awready}), 64'h2);
        chk("w1_wready", 64'({s_if[1].wready, s_if[0].wready}), 64'h2);
        tick();
        s_if[1].awvalid = 1'b0; s_if[1].wvalid = 1'b0;
        m_if.bvalid = 1'b1; m_if.bresp = 2'b00; m_if.bid = 4'd3;
        #1;
        chk("w1_bvalid", 64'({s_if[1].bvalid, s_if[0].bvalid}), 64'h2);
        chk("w1_bresp", 64'(s_if[1].bresp), 64'h0);
        chk("w1_bready_aw_quiet", 64'({m_if.bready, m_if.awvalid, m_if.wvalid}), 64'h4);
        tick();
        m_if.bvalid = 1'b0;
        #1;
        chk("w1_back_idle", 64'({s_if[1].bvalid, m_if.bready}), 64'h0);
        chk("w1_beats", 64'({8'(aw_beats), 8'(w_beats), 8'(b_beats)}), 64'h010101);

        // simultaneous reads from both masters, four rounds
        s_if[0].araddr = 32'h100; s_if[0].arvalid = 1'b1; s_if[0].rready = 1'b1;
        s_if[1].araddr = 32'h200; s_if[1].arvalid = 1'b1; s_if[1].rready = 1'b1;
        m_if.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = (i % 2) == 1;
            tick();
            chk($sformatf("rd%0d_araddr", i), 64'(m_if.araddr), g ? 64'h200 : 64'h100);
            chk($sformatf("rd%0d_arready", i), 64'({s_if[1].arready, s_if[0].arready}),
                g ? 64'h2 : 64'h1);
            tick();
            m_if.rvalid = 1'b1; m_if.rdata = 32'hC0DE_0000 + 32'(i);
            #1;
            chk($sformatf("rd%0d_rvalid", i), 64'({s_if[1].rvalid, s_if[0].rvalid}),
                g ? 64'h2 : 64'h1);
            chk($sformatf("rd%0d_rdata", i), 64'(g ? s_if[1].rdata : s_if[0].rdata),
                64'hC0DE_0000 + 64'(i));
            tick();
            m_if.rvalid = 1'b0;
        end
        s_if[0].arvalid = 1'b0; s_if[1].arvalid = 1'b0;

        // W leads AW by three cycles on master 0
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        s_if[0].wdata = 32'h1111_1111; s_if[0].wstrb = 4'hF; s_if[0].wvalid = 1'b1;
        s_if[0].bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wlead%0d_held", i), 64'({m_if.wvalid, s_if[0].wready}), 64'h0);
            tick();
        end
        s_if[0].awaddr = 32'h20; s_if[0].awvalid = 1'b1;
        tick();
        chk("wlead_addr_valids", 64'({m_if.awvalid, m_if.wvalid}), 64'h3);
        chk("wlead_wdata", 64'(m_if.wdata), 64'h1111_1111);
        tick();
        s_if[0].awvalid = 1'b0; s_if[0].wvalid = 1'b0;
        m_if.bvalid = 1'b1;
        #1;
        chk("wlead_bvalid", 64'({s_if[1].bvalid, s_if[0].bvalid}), 64'h1);
        tick();
        m_if.bvalid = 1'b0;
        #1;
        chk("wlead_beats", 64'({8'(aw_beats - aw0), 8'(w_beats - w0), 8'(b_beats - b0)}), 64'h010101);

        // AW and W together on master 1, W stalled one cycle by the slave
        aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
        s_if[1].awaddr = 32'h24; s_if[1].awvalid = 1'b1;
        s_if[1].wdata = 32'h2222_2222; s_if[1].wvalid = 1'b1;
        m_if.wready = 1'b0;
        tick();
        chk("wstall_addr", 64'({m_if.awvalid, m_if.wvalid, s_if[1].wready}), 64'h6);
        tick();
        chk("wstall_aw_masked", 64'({m_if.awvalid, s_if[1].awready, m_if.wvalid}), 64'h1);
        m_if.wready = 1'b1;
        #1;
        chk("wstall_wready", 64'({s_if[1].wready, s_if[0].wready}), 64'h2);
        tick();
        s_if[1].awvalid = 1'b0; s_if[1].wvalid = 1'b0;
        m_if.bvalid = 1'b1;
        #1;
        chk("wstall_bvalid", 64'({s_if[1].bvalid, s_if[0].bvalid}), 64'h2);
        tick();
        m_if.bvalid = 1'b0;
        #1;
        chk("wstall_beats", 64'({8'(aw_beats - aw0), 8'(w_beats - w0), 8'(b_beats - b0)}), 64'h010101);

        // concurrent write (master 0) and read (master 1), B stalled five cycles
        s_if[0].awaddr = 32'h30; s_if[0].awvalid = 1'b1; s_if[0].wvalid = 1'b1;
        s_if[1].araddr = 32'h300; s_if[1].arvalid = 1'b1;
        tick();
        chk("conc_addr_valids", 64'({m_if.awvalid, m_if.wvalid, m_if.arvalid}), 64'h7);
        chk("conc_addrs", 64'({m_if.awaddr, m_if.araddr}), {32'h30, 32'h300});
        tick();
        s_if[0].awvalid = 1'b0; s_if[0].wvalid = 1'b0; s_if[1].arvalid = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 32'hBEEF;
        #1;
        chk("conc_rvalid", 64'({s_if[1].rvalid, s_if[0].rvalid}), 64'h2);
        chk("conc_rdata", 64'(s_if[1].rdata), 64'hBEEF);
        chk("conc_b_wait", 64'({s_if[0].bvalid, m_if.bready}), 64'h1);
        tick();
        m_if.rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("conc_stall%0d", i),
                64'({s_if[0].bvalid, m_if.bready, m_if.arvalid, s_if[1].rvalid}), 64'h4);
            tick();
        end
        m_if.bvalid = 1'b1; m_if.bresp = 2'b10;
        #1;
        chk("conc_bvalid", 64'({s_if[1].bvalid, s_if[0].bvalid}), 64'h1);
        chk("conc_bresp", 64'(s_if[0].bresp), 64'h2);
        tick();
        m_if.bvalid = 1'b0; m_if.bresp = 2'b00;

        // reset asserted in W_RESP, then a tie after release
        s_if[1].awaddr = 32'h44; s_if[1].awvalid = 1'b1; s_if[1].wvalid = 1'b1;
        tick();
        tick();
        s_if[1].awvalid = 1'b0; s_if[1].wvalid = 1'b0;
        m_if.bvalid = 1'b1;
        #1;
        chk("rst_pre_bvalid", 64'(s_if[1].bvalid), 64'h1);
        areset = 1'b1;
        #1;
        chk("rst_outs_zero", 64'(hs_outs()), 64'h0);
        @(posedge aclk);
        #1 areset = 1'b0;
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        #1;
        chk("rst_stale_b", 64'({s_if[1].bvalid, s_if[0].bvalid, m_if.bready}), 64'h0);
        s_if[0].awaddr = 32'h40; s_if[0].awvalid = 1'b1; s_if[0].wvalid = 1'b1;
        s_if[1].awaddr = 32'h50; s_if[1].awvalid = 1'b1; s_if[1].wvalid = 1'b1;
        tick();
        chk("tie_grant0", 64'({m_if.awvalid, m_if.awaddr}), {31'h0, 1'b1, 32'h40});
        chk("tie_stale_b", 64'({s_if[1].bvalid, s_if[0].bvalid}), 64'h0);
        m_if.bvalid = 1'b0; m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        chk("tie_awready", 64'({s_if[1].awready, s_if[0].awready}), 64'h1);
        tick();
        s_if[0].awvalid = 1'b0; s_if[0].wvalid = 1'b0;
        m_if.bvalid = 1'b1;
        #1;
        chk("tie_bvalid0", 64'({s_if[1].bvalid, s_if[0].bvalid}), 64'h1);
        tick();
        m_if.bvalid = 1'b0;
        tick();
        chk("tie_next_grant1", 64'(m_if.awaddr), 64'h50);
        tick();
        s_if[1].awvalid = 1'b0; s_if[1].wvalid = 1'b0;
        m_if.bvalid = 1'b1;
        #1;
        chk("tie_bvalid1", 64'({s_if[1].bvalid, s_if[0].bvalid}), 64'h2);
        tick();
        m_if.bvalid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_arbiter_2to1.md
# axi4_lite_arbiter_2to1

Two-master to one-slave AXI4-Lite arbiter: the fan-in counterpart of the AXI4-Lite fanout. It shares a single downstream AXI4-Lite port between two upstream masters. Read and write channels are arbitrated independently with round-robin, with one outstanding transaction per channel. It sits where a fanout's downstream side, or two independent masters, must reach one register block or bridge.

## Interface
- CONFIG, no default: `axi4_lite_cfg_t`; fields A (address width), N (data bytes) and I (ID width) size all interfaces.
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- axi4_s[2]  `axi4_lite_if`  slave side: upstream masters 0 and 1 connect here.
- axi4_m  `axi4_lite_if`  master side: connects to the shared downstream slave.

## Operation
- Two independent channel engines: write (AW/W/B) and read (AR/R). No interaction between them; a read and a write may be in flight simultaneously for different or the same master.
- Write engine states:
  - W_IDLE: request = `axi4_s[k].awvalid`; W is not required to request.
  - W_IDLE -> W_ADDR on any request, latching grant g.
  - W_ADDR: forward AW and W of master g; track aw_done and w_done flags; -> W_RESP when both are set, including when both handshakes occur in the same cycle.
  - W_RESP: route B to master g; -> W_IDLE on the B handshake; set last = g.
- Read engine states:
  - R_IDLE -> R_ADDR on `axi4_s[k].arvalid`.
  - R_ADDR -> R_RESP on the AR handshake.
  - R_RESP -> R_IDLE on the R handshake; set last = g.
- Round-robin, separate pointer per engine:
  - Both requesting: grant the master != last.
  - One requesting: grant it.
  - Reset value last = 1, so master 0 wins the first tie.
- Forwarding, combinational muxes selected by the registered g:
  - In W_ADDR: `m.awvalid = s[g].awvalid & ~aw_done`; `m.wvalid = s[g].wvalid & ~w_done`; `s[g].awready = m.awready & ~aw_done`; same pattern for W.
  - In W_RESP: `m.bready = s[g].bready`; `s[g].bvalid = m.bvalid`; bresp routed to g.
  - Read channel uses the same pattern.
  - Payload (addr, prot, data, strb, ID) passes through unmodified.
- Non-granted master and idle states:
  - All ready and valid outputs toward the non-granted master are 0.
  - In IDLE states all downstream valids and readies are 0.
- The arbiter never drops or reorders a beat. An upstream valid held while not granted simply waits (AXI rule: valid stays asserted).

## Timing
- Reset, asynchronous assert: both engines go to IDLE, aw_done = w_done = 0, both last = 1, g = 0.
  - All outputs low: `m.awvalid`, `m.wvalid`, `m.bready`, `m.arvalid`, `m.rready`, and every `s[k]` ready/valid.
  - A transaction in flight at reset is abandoned; any late downstream response is not forwarded.
- Grant latency: a request sampled in IDLE at edge n gives g valid and forwarding from cycle n+1. One cycle of arbitration overhead.
- Minimum write occupancy with a zero-wait slave: IDLE, ADDR, RESP = 3 cycles. Read minimum is also 3 cycles. Back-to-back from IDLE to the next grant takes no extra cycle beyond IDLE.
- No combinational path from `m.*ready` to `m.*valid`. The ready-to-ready paths are combinational, which is allowed by AXI.
- A request arriving while the engine is busy waits until the engine returns to IDLE.
- A request withdrawn in IDLE is a protocol violation and is not handled.

## Structure
- Shared package `axi4_lite_pkg` (existing) holds `axi4_lite_cfg_t`. Add state enums `arb_wr_state_t` (W_IDLE, W_ADDR, W_RESP) and `arb_rd_state_t` (R_IDLE, R_ADDR, R_RESP).
- One sub-module: `axi4_lite_rr_arb2`, a 2-way round-robin grant register with req[1:0], take, done, grant and last. Instantiated once per engine.
- Top level contains the two engines and the muxes, in the same split as the fanout: write logic and read logic kept separate.

## Test plan
- Single write from master 1 (addr 0x10, data 0xA5A5_A5A5, zero-wait slave): downstream sees AW+W in cycle 2 and B in cycle 3; bresp OKAY returned only to master 1; master 0 sees no bvalid.
- Simultaneous reads from both masters, repeated 4 times: grants alternate 0,1,0,1; each master gets only its own rdata.
- W leads AW by 3 cycles, then AW arrives; also AW and W in the same cycle: exactly one AW beat and one W beat downstream in both cases; W_RESP is entered once.
- Concurrent write (master 0) and read (master 1), with the slave stalling bvalid 5 cycles: read completes independently; master 0's write completes after the stall.
- areset asserted in W_RESP: all outputs 0 immediately. After release, a tie grants master 0, and the stale bvalid is ignored.
- Random valid/ready back-pressure, 1000 transactions, protocol checker on all three ports: no beat lost or duplicated; valid stable until ready; every response routed to its originating master.
